// File: rtl/cnt_sched.sv
// ---------------------------------------------------------------------------
// cnt_sched
//
// Purpose:
//   Time-shares one CNT_W-bit up-counter between NUM_REQ requesters.
//   Each requester asks for a counting window of a given length. Windows are
//   granted round-robin and are never pre-empted. For every granted window
//   the counter runs 0..wl-1 while the owner's grant is high. A one-cycle
//   done pulse then goes back to the owner.
//
// Ports:
//   CLK    in   1              clock, all state updates on posedge
//   RST    in   1              synchronous active-high reset
//   req    in   NUM_REQ        per-requester request level, held until done
//   len    in   NUM_REQ*CNT_W  packed window lengths, requester i uses
//                              len[i*CNT_W +: CNT_W]; a length of 0 counts
//                              as 1
//   abort  in   1              (only with CNT_SCHED_ABORT_EN) kills the
//                              running window without a done pulse
//   gnt    out  NUM_REQ        one-hot grant, high for the whole window
//   done   out  NUM_REQ        one-cycle completion pulse to the owner
//   busy   out  1              high whenever the scheduler is not idle
//   cnt    out  CNT_W          shared counter value
//
// Configuration:
//   CNT_SCHED_ABORT_EN  when defined, adds the abort input. Without it every
//                       granted window runs to completion.
// ---------------------------------------------------------------------------
module cnt_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
`ifdef CNT_SCHED_ABORT_EN
  input  logic                     abort,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } stateT;

  // Registered state
  stateT              r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_wl;

  // Combinational next values
  stateT              w_nextState;
  logic [CNT_W-1:0]   w_nextCnt;
  logic [NUM_REQ-1:0] w_nextGnt;
  logic [NUM_REQ-1:0] w_nextDone;
  logic [PTR_W-1:0]   w_nextPtr;
  logic [PTR_W-1:0]   w_nextOwner;
  logic [CNT_W-1:0]   w_nextWl;

  // Arbitration results
  logic               w_anyReq;
  logic [PTR_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_winnerOneHot;
  logic [NUM_REQ-1:0] w_ownerOneHot;
  logic [CNT_W-1:0]   w_winLen;
  logic [CNT_W-1:0]   w_winLenAdj;
  logic               w_lastCount;
  logic               w_abort;

  // Round-robin search: the candidate order starts just after the last
  // owner and wraps, so whoever was served most recently goes last.
  function automatic logic [PTR_W-1:0] pickWinner(
    input logic [NUM_REQ-1:0] reqs,
    input logic [PTR_W-1:0]   ptr
  );
    logic found;
    int   idx;
    found      = 1'b0;
    pickWinner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && reqs[idx]) begin
        found      = 1'b1;
        pickWinner = PTR_W'(idx);
      end
    end
  endfunction

`ifdef CNT_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Winner selection and its window length. A zero length is promoted to 1
  // so every grant lasts at least one cycle and wl-1 never underflows.
  always_comb begin
    w_anyReq       = |req;
    w_winner       = pickWinner(req, r_ptr);
    w_winnerOneHot = NUM_REQ'(1) << w_winner;
    w_ownerOneHot  = NUM_REQ'(1) << r_owner;
    w_winLen       = len[int'(w_winner)*CNT_W +: CNT_W];
    w_winLenAdj    = (w_winLen == '0) ? CNT_W'(1) : w_winLen;
    w_lastCount    = (r_cnt == (r_wl - CNT_W'(1)));
  end

  // Next-state and next-output logic. All outputs are registered, so this
  // block decides what gnt/done/cnt look like in the following cycle. The
  // owner's length is latched at grant time, which is why later changes to
  // len or req cannot stretch or shorten a running window.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextGnt   = r_gnt;
    w_nextDone  = '0;
    w_nextPtr   = r_ptr;
    w_nextOwner = r_owner;
    w_nextWl    = r_wl;

    case (r_state)
      ST_IDLE: begin
        if (w_anyReq) begin
          w_nextState = ST_RUN;
          w_nextGnt   = w_winnerOneHot;
          w_nextCnt   = '0;
          w_nextOwner = w_winner;
          w_nextWl    = w_winLenAdj;
        end
      end

      ST_RUN: begin
        if (w_abort) begin
          // Aborted owner still moves to the back of the queue.
          w_nextState = ST_IDLE;
          w_nextGnt   = '0;
          w_nextCnt   = '0;
          w_nextPtr   = r_owner;
        end else if (w_lastCount) begin
          w_nextState = ST_DONE;
          w_nextGnt   = '0;
          w_nextDone  = w_ownerOneHot;
          w_nextCnt   = '0;
          w_nextPtr   = r_owner;
        end else begin
          w_nextCnt   = r_cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // The done pulse lasts exactly one cycle. Arbitration for the next
        // window happens in the idle cycle that follows.
        w_nextState = ST_IDLE;
        w_nextGnt   = '0;
        w_nextCnt   = '0;
      end

      default: begin
        w_nextState = ST_IDLE;
        w_nextGnt   = '0;
        w_nextCnt   = '0;
      end
    endcase
  end

  // State register. Reset wins in every state, so a window killed by reset
  // never produces a done pulse. The pointer resets to the last requester,
  // which gives requester 0 first priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_ptr   <= PTR_W'(NUM_REQ - 1);
      r_owner <= '0;
      r_wl    <= CNT_W'(1);
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_gnt   <= w_nextGnt;
      r_done  <= w_nextDone;
      r_ptr   <= w_nextPtr;
      r_owner <= w_nextOwner;
      r_wl    <= w_nextWl;
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = (r_state != ST_IDLE);
  assign cnt  = r_cnt;

endmodule

// File: tb/tb_cnt_sched.sv
// ---------------------------------------------------------------------------
// tb_cnt_sched
//
// Directed testbench for cnt_sched with NUM_REQ=4 and CNT_W=8. Inputs are
// driven 1 time unit after each rising edge, and outputs are sampled at that
// same point, once the registered outputs have settled. Expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_cnt_sched;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;

  logic                     CLK;
  logic                     RST;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
`ifdef CNT_SCHED_ABORT_EN
  logic                     abort;
`endif
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [CNT_W-1:0]         cnt;

  int assertCount;
  int failCount;

  cnt_sched #(
    .NUM_REQ(NUM_REQ),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .req  (req),
    .len  (len),
`ifdef CNT_SCHED_ABORT_EN
    .abort(abort),
`endif
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .cnt  (cnt)
  );

  // Free-running clock with a 10-unit period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Counts one comparison and reports it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advances one cycle and leaves time just past the rising edge
  task automatic applyStimulus();
    @(posedge CLK);
    #1;
  endtask

  // Synchronous reset pulse of one cycle, with all requests cleared
  task automatic doReset();
    req = '0;
    len = '0;
`ifdef CNT_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    RST = 1'b1;
    applyStimulus();
    RST = 1'b0;
  endtask

  task automatic setLen(input int idx, input logic [CNT_W-1:0] value);
    len[idx*CNT_W +: CNT_W] = value;
  endtask

  int          gntCycles;
  logic [7:0]  lastCnt;
  logic [3:0]  expGnt;

  initial begin
    assertCount = 0;
    failCount   = 0;
    RST = 1'b0;
    req = '0;
    len = '0;
`ifdef CNT_SCHED_ABORT_EN
    abort = 1'b0;
`endif

    // ---- Reset values ------------------------------------------------------
    doReset();
    checkOutput("rst_gnt",  32'(gnt),  32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_cnt",  32'(cnt),  32'h0);

    // ---- Single window: req0, len0=3 ---------------------------------------
    req = 4'b0001;
    setLen(0, 8'd3);
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkOutput($sformatf("w3_gnt_c%0d", c + 1), 32'(gnt), 32'h1);
      checkOutput($sformatf("w3_cnt_c%0d", c + 1), 32'(cnt), 32'(c));
      checkOutput($sformatf("w3_busy_c%0d", c + 1), 32'(busy), 32'h1);
    end
    applyStimulus();
    checkOutput("w3_done_c4", 32'(done), 32'h1);
    checkOutput("w3_gnt_c4",  32'(gnt),  32'h0);
    checkOutput("w3_busy_c4", 32'(busy), 32'h1);
    req = 4'b0000;
    applyStimulus();
    checkOutput("w3_busy_c5", 32'(busy), 32'h0);
    checkOutput("w3_done_c5", 32'(done), 32'h0);

    // ---- Round robin: all requesting, all len=1 ----------------------------
    doReset();
    req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) setLen(i, 8'd1);
    for (int w = 0; w < 5; w++) begin
      expGnt = 4'(1 << (w % NUM_REQ));
      applyStimulus();
      checkOutput($sformatf("rr_gnt_w%0d", w), 32'(gnt), 32'(expGnt));
      checkOutput($sformatf("rr_cnt_w%0d", w), 32'(cnt), 32'h0);
      applyStimulus();
      checkOutput($sformatf("rr_done_w%0d", w), 32'(done), 32'(expGnt));
      checkOutput($sformatf("rr_gntoff_w%0d", w), 32'(gnt), 32'h0);
      if (w == 4) req = 4'b0000;
      applyStimulus();
      checkOutput($sformatf("rr_idle_w%0d", w), 32'(busy), 32'h0);
      checkOutput($sformatf("rr_idlegnt_w%0d", w), 32'(gnt), 32'h0);
    end

    // ---- len0=0 behaves like len=1 -----------------------------------------
    req = 4'b0001;
    setLen(0, 8'd0);
    applyStimulus();
    checkOutput("l0_gnt", 32'(gnt), 32'h1);
    checkOutput("l0_cnt", 32'(cnt), 32'h0);
    applyStimulus();
    checkOutput("l0_done", 32'(done), 32'h1);
    checkOutput("l0_gntoff", 32'(gnt), 32'h0);
    req = 4'b0000;
    applyStimulus();
    checkOutput("l0_idle", 32'(busy), 32'h0);

    // ---- len0=0xFF: 255 cycles, counter tops out at 0xFE -------------------
    req = 4'b0001;
    setLen(0, 8'hFF);
    applyStimulus();
    gntCycles = 0;
    lastCnt   = 8'h00;
    while (gnt == 4'b0001 && gntCycles < 300) begin
      gntCycles++;
      lastCnt = cnt;
      applyStimulus();
    end
    checkOutput("ff_cycles", 32'(gntCycles), 32'd255);
    checkOutput("ff_lastcnt", 32'(lastCnt), 32'hFE);
    checkOutput("ff_done", 32'(done), 32'h1);
    req = 4'b0000;
    applyStimulus();
    checkOutput("ff_idle", 32'(busy), 32'h0);

    // ---- Owner changes during its window are ignored -----------------------
    req = 4'b0010;
    setLen(1, 8'd5);
    applyStimulus();
    checkOutput("mid_gnt_c0", 32'(gnt), 32'h2);
    applyStimulus();
    checkOutput("mid_cnt_c1", 32'(cnt), 32'h1);
    req = 4'b0100;
    setLen(1, 8'd1);
    setLen(2, 8'd2);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("mid_cnt_c4", 32'(cnt), 32'h4);
    checkOutput("mid_gnt_c4", 32'(gnt), 32'h2);
    applyStimulus();
    checkOutput("mid_done1", 32'(done), 32'h2);
    checkOutput("mid_gntoff", 32'(gnt), 32'h0);
    applyStimulus();
    checkOutput("mid_idle_gnt", 32'(gnt), 32'h0);
    checkOutput("mid_idle_busy", 32'(busy), 32'h0);
    applyStimulus();
    checkOutput("mid_gnt2", 32'(gnt), 32'h4);
    checkOutput("mid_gnt2_cnt", 32'(cnt), 32'h0);
    applyStimulus();
    checkOutput("mid_gnt2_c1", 32'(cnt), 32'h1);
    applyStimulus();
    checkOutput("mid_done2", 32'(done), 32'h4);
    req = 4'b0000;
    applyStimulus();

    // ---- Reset in the middle of a window -----------------------------------
    // The pointer now sits at 2, so req0|req1 grants 0 first. Without the
    // reset the next winner would be 1; after the reset it must be 0 again.
    req = 4'b0011;
    setLen(0, 8'd6);
    setLen(1, 8'd1);
    applyStimulus();
    checkOutput("rmid_gnt", 32'(gnt), 32'h1);
    applyStimulus();
    applyStimulus();
    checkOutput("rmid_cnt2", 32'(cnt), 32'h2);
    RST = 1'b1;
    applyStimulus();
    RST = 1'b0;
    checkOutput("rmid_gnt_off", 32'(gnt), 32'h0);
    checkOutput("rmid_cnt0", 32'(cnt), 32'h0);
    checkOutput("rmid_done0", 32'(done), 32'h0);
    checkOutput("rmid_busy0", 32'(busy), 32'h0);
    applyStimulus();
    checkOutput("rmid_regrant", 32'(gnt), 32'h1);
    req = 4'b0000;
    doReset();

`ifdef CNT_SCHED_ABORT_EN
    // ---- Abort of owner 2 at cnt=1 -----------------------------------------
    req = 4'b0100;
    setLen(2, 8'd4);
    applyStimulus();
    checkOutput("ab_gnt", 32'(gnt), 32'h4);
    applyStimulus();
    checkOutput("ab_cnt1", 32'(cnt), 32'h1);
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkOutput("ab_gntoff", 32'(gnt), 32'h0);
    checkOutput("ab_done", 32'(done), 32'h0);
    checkOutput("ab_busy", 32'(busy), 32'h0);
    checkOutput("ab_cnt", 32'(cnt), 32'h0);
    req = 4'b1100;
    setLen(3, 8'd1);
    applyStimulus();
    checkOutput("ab_next", 32'(gnt), 32'h8);
    req = 4'b0000;
    doReset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
